// File: rtl/atomrvcore_lsu.sv
// atomrvcore_lsu: load/store unit driving a word-addressed DCCM with a one-cycle registered read
//   clk_i, rst_i           : clock, synchronous active-high reset
//   req_*_i / req_ready_o  : single-outstanding load/store request from execute
//   dmem_*                 : DCCM port (word address, whole-word write, registered read)
//   wb_valid_o/wb_rd_o/wb_data_o : one-cycle extended load result to writeback
//   err_o                  : one-cycle pulse for a misaligned or illegal request
module atomrvcore_lsu #(
    parameter int DATAWIDTH        = 32,
    parameter int REG_ADRESS_WIDTH = 5
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        req_valid_i,
    output logic                        req_ready_o,
    input  logic                        req_we_i,
    input  logic [2:0]                  req_funct3_i,
    input  logic [DATAWIDTH-1:0]        req_addr_i,
    input  logic [DATAWIDTH-1:0]        req_wdata_i,
    input  logic [REG_ADRESS_WIDTH-1:0] req_rd_i,
    output logic [DATAWIDTH-1:0]        dmem_addr_o,
    output logic [DATAWIDTH-1:0]        dmem_wdata_o,
    output logic                        dmem_wr_en_o,
    output logic                        dmem_rd_en_o,
    input  logic [DATAWIDTH-1:0]        dmem_rdata_i,
    output logic                        wb_valid_o,
    output logic [REG_ADRESS_WIDTH-1:0] wb_rd_o,
    output logic [DATAWIDTH-1:0]        wb_data_o,
    output logic                        err_o
);
    typedef enum logic [2:0] {IDLE, ST_WR, LD_RD, LD_CAP, RMW_RD, RMW_MRG, RMW_WR} state_t;
    state_t                        state_q, state_d;
    logic [DATAWIDTH-1:0]          addr_q, data_q, wb_data_q, ld_val, merged, mask;
    logic [2:0]                    f3_q;
    logic [REG_ADRESS_WIDTH-1:0]   rd_q;
    logic                          wb_valid_q, err_q, accept, illegal;
    logic [4:0]                    sh;
    logic [7:0]                    lane_b;
    logic [15:0]                   lane_h;

    assign req_ready_o  = state_q == IDLE;
    assign accept       = req_valid_i & req_ready_o;
    assign illegal      = (req_funct3_i == 3'b011) | (req_funct3_i[2:1] == 2'b11) |
                          (req_funct3_i[2] & req_we_i) |
                          ((req_funct3_i[1:0] == 2'b01) & req_addr_i[0]) |
                          ((req_funct3_i == 3'b010) & (req_addr_i[1:0] != 2'b00));
    assign dmem_addr_o  = {addr_q[DATAWIDTH-1:2], 2'b00};
    // data_q holds the store data, and after RMW_MRG the merged word
    assign dmem_wdata_o = data_q;
    assign dmem_wr_en_o = ((state_q == ST_WR) | (state_q == RMW_WR)) & ~rst_i;
    assign dmem_rd_en_o = ((state_q == LD_RD) | (state_q == RMW_RD)) & ~rst_i;
    assign wb_valid_o   = wb_valid_q;
    assign wb_rd_o      = rd_q;
    assign wb_data_o    = wb_data_q;
    assign err_o        = err_q;

    assign lane_b = 8'(dmem_rdata_i >> {addr_q[1:0], 3'b000});
    assign lane_h = 16'(dmem_rdata_i >> {addr_q[1], 4'b0000});
    // funct3[2] selects zero-extension, funct3[1] selects a full word
    assign ld_val = f3_q[1] ? dmem_rdata_i :
                    f3_q[0] ? {{(DATAWIDTH-16){lane_h[15] & ~f3_q[2]}}, lane_h} :
                              {{(DATAWIDTH-8){lane_b[7] & ~f3_q[2]}}, lane_b};
    assign sh     = f3_q[0] ? {addr_q[1], 4'b0000} : {addr_q[1:0], 3'b000};
    assign mask   = (f3_q[0] ? DATAWIDTH'(16'hFFFF) : DATAWIDTH'(8'hFF)) << sh;
    assign merged = (dmem_rdata_i & ~mask) | ((data_q << sh) & mask);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept && !illegal)
                         state_d = !req_we_i ? LD_RD : (req_funct3_i[1:0] == 2'b10) ? ST_WR : RMW_RD;
            LD_RD:   state_d = LD_CAP;
            RMW_RD:  state_d = RMW_MRG;
            RMW_MRG: state_d = RMW_WR;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            data_q     <= '0;
            f3_q       <= '0;
            rd_q       <= '0;
            wb_data_q  <= '0;
            wb_valid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            err_q      <= accept & illegal;
            wb_valid_q <= state_q == LD_CAP;
            if (accept && !illegal) begin
                addr_q <= req_addr_i;
                data_q <= req_wdata_i;
                f3_q   <= req_funct3_i;
                rd_q   <= req_rd_i;
            end
            if (state_q == LD_CAP) wb_data_q <= ld_val;
            if (state_q == RMW_MRG) data_q <= merged;
        end
    end
endmodule

// File: tb/tb_atomrvcore_lsu.sv
// tb_atomrvcore_lsu: randomized and directed check of atomrvcore_lsu against a byte-level memory model
module tb_atomrvcore_lsu;
    logic        clk_i = 1'b0, rst_i = 1'b1, fill = 1'b0;
    logic        req_valid_i = 1'b0, req_we_i = 1'b0;
    logic [2:0]  req_funct3_i = '0;
    logic [31:0] req_addr_i = '0, req_wdata_i = '0;
    logic [4:0]  req_rd_i = '0;
    logic        req_ready_o, dmem_wr_en_o, dmem_rd_en_o, wb_valid_o, err_o;
    logic [31:0] dmem_addr_o, dmem_wdata_o, dmem_rdata_i, wb_data_o;
    logic [4:0]  wb_rd_o;
    logic [31:0] mem [64];
    logic [7:0]  ref_mem [256];
    int          n_chk = 0, n_fail = 0;

    atomrvcore_lsu dut (
        .clk_i(clk_i), .rst_i(rst_i), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_we_i(req_we_i), .req_funct3_i(req_funct3_i), .req_addr_i(req_addr_i),
        .req_wdata_i(req_wdata_i), .req_rd_i(req_rd_i), .dmem_addr_o(dmem_addr_o),
        .dmem_wdata_o(dmem_wdata_o), .dmem_wr_en_o(dmem_wr_en_o), .dmem_rd_en_o(dmem_rd_en_o),
        .dmem_rdata_i(dmem_rdata_i), .wb_valid_o(wb_valid_o), .wb_rd_o(wb_rd_o),
        .wb_data_o(wb_data_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) begin
        if (fill)
            for (int i = 0; i < 64; i++)
                mem[i] <= {ref_mem[4*i+3], ref_mem[4*i+2], ref_mem[4*i+1], ref_mem[4*i]};
        else begin
            if (dmem_wr_en_o) mem[dmem_addr_o[7:2]] <= dmem_wdata_o;
            if (dmem_rd_en_o) dmem_rdata_i <= mem[dmem_addr_o[7:2]];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input logic [7:0] a);
        int b;
        b = int'(a) & 'hFC;
        return {ref_mem[b+3], ref_mem[b+2], ref_mem[b+1], ref_mem[b]};
    endfunction

    function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [7:0] a);
        logic [15:0] h;
        int v;
        if (f3[1:0] == 2'd0) begin
            v = f3[2] ? int'(ref_mem[a]) : int'($signed(ref_mem[a]));
        end else if (f3[1:0] == 2'd1) begin
            h = {ref_mem[a+8'd1], ref_mem[a]};
            v = f3[2] ? int'(h) : int'($signed(h));
        end else v = int'(ref_word(a));
        return 32'(v);
    endfunction

    function automatic logic is_illegal(input logic we, input logic [2:0] f3, input logic [7:0] a);
        return f3 == 3'd3 || f3 >= 3'd6 || (f3[2] && we) ||
               (f3[1:0] == 2'd1 && a[0]) || (f3 == 3'd2 && a[1:0] != 2'd0);
    endfunction

    task automatic drive(input logic we, input logic [2:0] f3, input logic [7:0] a,
                         input logic [31:0] wd, input logic [4:0] rd);
        req_valid_i = 1'b1; req_we_i = we; req_funct3_i = f3;
        req_addr_i = {24'd0, a}; req_wdata_i = wd; req_rd_i = rd;
    endtask

    task automatic op(input logic we, input logic [2:0] f3, input logic [7:0] a,
                      input logic [31:0] wd, input logic [4:0] rd);
        logic ill, is_sw;
        int exp_end, cyc, nwr, nrd, nwb, nerr, nbad;
        logic [31:0] exp_d, wb_d;
        logic [4:0] wb_r;
        ill = is_illegal(we, f3, a);
        is_sw = we && f3[1:0] == 2'd2;
        exp_d = exp_load(f3, a);
        exp_end = ill ? 1 : !we ? 3 : is_sw ? 2 : 4;
        nwr = 0; nrd = 0; nwb = 0; nerr = 0; nbad = 0; wb_d = '0; wb_r = '0;
        chk("ready_before", {31'd0, req_ready_o}, 32'd1);
        drive(we, f3, a, wd, rd);
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        for (cyc = 1; cyc < 12; cyc++) begin
            if (dmem_wr_en_o || dmem_rd_en_o) chk("dmem_addr", dmem_addr_o, {24'd0, a[7:2], 2'b00});
            nwr += int'(dmem_wr_en_o);
            nrd += int'(dmem_rd_en_o);
            nbad += int'((dmem_wr_en_o && dmem_rd_en_o) || (wb_valid_o && err_o));
            nerr += int'(err_o);
            if (wb_valid_o) begin nwb++; wb_d = wb_data_o; wb_r = wb_rd_o; end
            if (req_ready_o) break;
            @(posedge clk_i); #1;
        end
        chk("busy_cycles", 32'(cyc), 32'(exp_end));
        chk("wr_pulses", 32'(nwr), (!ill && we) ? 32'd1 : 32'd0);
        chk("rd_pulses", 32'(nrd), (!ill && !is_sw) ? 32'd1 : 32'd0);
        chk("exclusive", 32'(nbad), 32'd0);
        chk("wb_pulses", 32'(nwb), (!ill && !we) ? 32'd1 : 32'd0);
        chk("err_pulses", 32'(nerr), ill ? 32'd1 : 32'd0);
        if (!ill && !we) begin
            chk("wb_data", wb_d, exp_d);
            chk("wb_rd", {27'd0, wb_r}, {27'd0, rd});
        end
        if (!ill && we) begin
            for (int i = 0; i < (1 << f3[1:0]); i++) ref_mem[a + 8'(i)] = wd[8*i +: 8];
            chk("mem_word", mem[a[7:2]], ref_word(a));
        end
    endtask

    task automatic rst_during(input logic [2:0] f3, input logic [7:0] a, input logic [31:0] wd);
        drive(1'b1, f3, a, wd, 5'd0);
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        rst_i = 1'b1;
        #0;
        chk("rst_no_wr", {31'd0, dmem_wr_en_o}, 32'd0);
        chk("rst_no_rd", {31'd0, dmem_rd_en_o}, 32'd0);
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        chk("rst_ready", {31'd0, req_ready_o}, 32'd1);
        chk("rst_outs", {dmem_addr_o | dmem_wdata_o | wb_data_o},  32'd0);
        chk("rst_flags", {27'd0, wb_valid_o, err_o, dmem_wr_en_o, dmem_rd_en_o, |wb_rd_o}, 32'd0);
        @(posedge clk_i); #1;
        chk("rst_ready_after", {31'd0, req_ready_o}, 32'd1);
        chk("rst_mem", mem[a[7:2]], ref_word(a));
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'($urandom);
        fill = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        fill = 1'b0;
        chk("reset_ready", {31'd0, req_ready_o}, 32'd1);
        chk("reset_outs", dmem_addr_o | dmem_wdata_o | wb_data_o, 32'd0);
        chk("reset_flags", {27'd0, wb_valid_o, err_o, dmem_wr_en_o, dmem_rd_en_o, |wb_rd_o}, 32'd0);
        rst_i = 1'b0;
        @(posedge clk_i); #1;
        op(1, 3'b010, 8'h10, 32'hDEADBEEF, 5'd0);
        op(0, 3'b010, 8'h10, 32'd0, 5'd5);
        chk("lw_dead", exp_load(3'b010, 8'h10), 32'hDEADBEEF);
        op(1, 3'b010, 8'h20, 32'h80817F01, 5'd0);
        for (int i = 0; i < 4; i++) op(0, 3'b000, 8'h20 + 8'(i), 32'd0, 5'(i + 1));
        op(0, 3'b100, 8'h23, 32'd0, 5'd0);
        op(0, 3'b001, 8'h22, 32'd0, 5'd6);
        op(0, 3'b101, 8'h22, 32'd0, 5'd7);
        op(1, 3'b010, 8'h40, 32'h11223344, 5'd0);
        op(1, 3'b000, 8'h41, 32'h000000AA, 5'd0);
        chk("sb_word", mem[16], 32'h1122AA44);
        op(1, 3'b001, 8'h42, 32'h0000BEEF, 5'd0);
        chk("sh_word", mem[16], 32'hBEEFAA44);
        op(0, 3'b010, 8'h06, 32'd0, 5'd1);
        op(1, 3'b001, 8'h03, 32'h1234, 5'd0);
        op(0, 3'b011, 8'h00, 32'd0, 5'd1);
        op(1, 3'b100, 8'h00, 32'h55, 5'd0);
        // back-to-back loads with valid held: second accepted on the first result's cycle
        drive(0, 3'b010, 8'h10, 32'd0, 5'd7);
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk_i); #1;
            if (c == 3 || c == 6) begin
                chk("b2b_wb", {31'd0, wb_valid_o}, 32'd1);
                chk("b2b_ready", {31'd0, req_ready_o}, 32'd1);
                chk("b2b_data", wb_data_o, 32'hDEADBEEF);
                chk("b2b_rd", {27'd0, wb_rd_o}, (c == 3) ? 32'd7 : 32'd9);
                req_rd_i = 5'd9;
            end else begin
                chk("b2b_busy", {31'd0, req_ready_o}, 32'd0);
                chk("b2b_nowb", {31'd0, wb_valid_o}, 32'd0);
                if (c == 4) begin
                    chk("b2b_rd_en", {31'd0, dmem_rd_en_o}, 32'd1);
                    req_valid_i = 1'b0;
                end
            end
        end
        rst_during(3'b000, 8'h41, 32'h000000CC);
        rst_during(3'b010, 8'h44, 32'h77777777);
        for (int n = 0; n < 300; n++)
            op(1'($urandom), 3'($urandom), 8'($urandom), $urandom, 5'($urandom));
        begin
            int bad;
            bad = 0;
            for (int i = 0; i < 64; i++) bad += int'(mem[i] !== ref_word(8'(4 * i)));
            chk("final_mem", 32'(bad), 32'd0);
        end
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule

// File: doc/atomrvcore_lsu.md
Name: atomrvcore_lsu

Overview:
- Load/store unit: the initiator side of the data-memory port. Accepts one load/store request at a time from the execute stage, drives the word-addressed DCCM (DWR_EN/DR_EN, one-cycle registered read), and returns sign/zero-extended load data with its destination register to writeback.
- Sub-word stores are performed as read-modify-write, because the DCCM writes whole words only.

Parameters:
- DATAWIDTH, 32, data and address width.
- REG_ADRESS_WIDTH, 5, destination register index width.

Ports:
- clk_i  input  1  clock, rising edge
- rst_i  input  1  synchronous reset, active high
- req_valid_i  input  1  request valid
- req_ready_o  output  1  unit can accept a request
- req_we_i  input  1  1 = store, 0 = load
- req_funct3_i  input  3  000 B, 001 H, 010 W, 100 BU (load only), 101 HU (load only)
- req_addr_i  input  DATAWIDTH  byte address
- req_wdata_i  input  DATAWIDTH  store data, low bytes used for B/H
- req_rd_i  input  REG_ADRESS_WIDTH  load destination register
- dmem_addr_o  output  DATAWIDTH  word-aligned address to DCCM, bits[1:0]=0
- dmem_wdata_o  output  DATAWIDTH  DCCM write data
- dmem_wr_en_o  output  1  DCCM write enable
- dmem_rd_en_o  output  1  DCCM read enable
- dmem_rdata_i  input  DATAWIDTH  DCCM read data, valid the cycle after dmem_rd_en_o
- wb_valid_o  output  1  one-cycle load result pulse
- wb_rd_o  output  REG_ADRESS_WIDTH  load destination register
- wb_data_o  output  DATAWIDTH  extended load data
- err_o  output  1  one-cycle pulse: misaligned or illegal request

Behaviour:
- Clock and reset: single clock clk_i; rst_i is synchronous, active high.
- Reset values: state IDLE; all outputs 0 except req_ready_o=1.
- Reset mid-operation: FSM returns to IDLE at the next edge. dmem_wr_en_o and dmem_rd_en_o are gated by ~rst_i, so no DCCM access occurs in a reset cycle.
- Output sourcing: all outputs are driven from registers or decoded from the state register only; no combinational path from req_*.
- Handshake: accept when req_valid_i & req_ready_o. req_ready_o=1 only in IDLE.
- Accepted request fields: captured into internal registers.
- Illegal requests:
  - H/HU with addr[0]=1.
  - W with addr[1:0]!=0.
  - funct3 011/11x.
  - funct3 1xx with store.
  - Response: err_o=1 in the next cycle; no DCCM access; no wb pulse; FSM stays in IDLE.
- States: IDLE, ST_WR, LD_RD, LD_CAP, RMW_RD, RMW_MRG, RMW_WR. Cycle 0 = accept.
- SW: cycle 1 ST_WR (dmem_wr_en_o=1, wdata=req_wdata); cycle 2 IDLE.
- Load: cycle 1 LD_RD (dmem_rd_en_o=1); cycle 2 LD_CAP (extract lane from dmem_rdata_i, register result); cycle 3 IDLE with wb_valid_o=1 for exactly one cycle. A new request may be accepted in cycle 3.
- Lane extraction, off = addr[1:0]:
  - B/BU: byte lane off.
  - H/HU: half lane addr[1].
  - B/H sign-extend; BU/HU zero-extend; W passes through.
- wb_rd_o=0: loads to rd 0 still pulse wb_valid_o with wb_rd_o=0; writeback discards them.
- SB/SH: cycle 1 RMW_RD (read); cycle 2 RMW_MRG (replace byte lane off with wdata[7:0], or half lane addr[1] with wdata[15:0], into the merge register); cycle 3 RMW_WR (dmem_wr_en_o=1, merged data); cycle 4 IDLE. Untouched lanes are preserved bit-exact.
- dmem_addr_o: held at {addr[31:2],2'b00} for the whole transaction.
- Enable exclusivity: dmem_wr_en_o and dmem_rd_en_o are never high together.
- wb pulses: wb_valid_o and err_o are single-cycle and never high together.

Test Plan:
- SW addr 0x0000_0010 data 0xDEADBEEF, then LW rd=5 same addr: wr_en in cycle 1 of store; load wb_valid 3 cycles after accept, wb_rd=5, data 0xDEADBEEF.
- Word 0x8081_7F01 at 0x20; LB off 0..3 returns 0x0000_0001, 0x0000_007F, 0xFFFF_FF81, 0xFFFF_FF80; LBU off 3 returns 0x0000_0080; LH 0x22 returns 0xFFFF_8081; LHU 0x22 returns 0x0000_8081.
- Word 0x1122_3344 at 0x40; SB 0xAA to 0x41 gives 0x1122_AA44; SH 0xBEEF to 0x42 gives 0xBEEF_AA44. Check 4-cycle busy and exactly one wr_en pulse per store.
- LW 0x06, SH 0x03, funct3=011 load, and LBU-encoded store: err_o pulses one cycle each; no rd/wr enable; req_ready_o stays 1.
- Back-to-back loads with req_valid_i held: second accepted in the same cycle the first wb_valid_o pulses. req_ready_o is low in all intermediate cycles.
- rst_i asserted during RMW_RD and during ST_WR: no dmem_wr_en_o; memory unchanged; outputs at reset values; req_ready_o=1 the cycle after release.
